// File: rtl/uart_pkg.sv
// Shared register offsets, CON bit positions and FSM state encodings for the MMIO UART.
// Imported by the register file and the receive core.
package uart_pkg;

    localparam logic [31:0] OFF_TXD = 32'h0;
    localparam logic [31:0] OFF_RXD = 32'h4;
    localparam logic [31:0] OFF_CON = 32'h8;

    localparam int CON_TX_BUSY   = 0;
    localparam int CON_RX_VALID  = 1;
    localparam int CON_RX_OVR    = 2;
    localparam int CON_FRAME_ERR = 3;
    localparam int CON_RX_INT_EN = 4;
    localparam int CON_TX_OVR    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM and shift register.
// rx_done / rx_ferr are single-cycle combinational pulses on the stop-sample edge.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_ferr
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        sync1_d = rx_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_done = 1'b0;
        rx_ferr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = ST_START;
            end
            // Half a bit in: a line that is high again was only a glitch.
            ST_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = sync2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (cnt_q == FULL) begin
                cnt_d   = '0;
                shift_d = {sync2_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = ST_STOP;
            end
            ST_STOP: if (cnt_q == FULL) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                rx_done = sync2_q;
                rx_ferr = !sync2_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, TX serializer, RX core and receive interrupt.
// Bus side is zero-wait: decode and Read_data are combinational, all side effects land on posedge clk.
module mmio_uart
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ  = 100000000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        Hit,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("mmio_uart: CLK_FREQ/BAUD must be at least 4");
    end

    logic [31:0] addr_off;
    logic        sel_txd, sel_rxd, sel_con;
    logic        wr_txd, wr_con, rd_rxd, tx_busy;
    logic [31:0] con_rd;
    logic [7:0]  rx_byte;
    logic        rx_done, rx_ferr;
    logic        unused_bits;

    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          uart_tx_q, uart_tx_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_overrun_q, rx_overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_int_en_q, rx_int_en_d;
    logic          tx_overrun_q, tx_overrun_d;
    logic          irq_q, irq_d;

    uart_rx_core #(.DIV(DIV)) u_rx (
        .clk     (clk),
        .rst_n   (reset),
        .rx_in   (uart_rx),
        .rx_byte (rx_byte),
        .rx_done (rx_done),
        .rx_ferr (rx_ferr)
    );

    assign unused_bits = ^{Address[1:0], Write_data[31:8]};

    always_comb begin
        addr_off = {Address[31:2], 2'b00} - {BASE_ADDR[31:2], 2'b00};
        sel_txd  = (addr_off == OFF_TXD);
        sel_rxd  = (addr_off == OFF_RXD);
        sel_con  = (addr_off == OFF_CON);
        Hit      = sel_txd | sel_rxd | sel_con;
        wr_txd   = MemWrite & sel_txd;
        wr_con   = MemWrite & sel_con;
        rd_rxd   = MemRead & sel_rxd;
        tx_busy  = (tx_state_q != ST_IDLE);

        con_rd                = '0;
        con_rd[CON_TX_BUSY]   = tx_busy;
        con_rd[CON_RX_VALID]  = rx_valid_q;
        con_rd[CON_RX_OVR]    = rx_overrun_q;
        con_rd[CON_FRAME_ERR] = frame_err_q;
        con_rd[CON_RX_INT_EN] = rx_int_en_q;
        con_rd[CON_TX_OVR]    = tx_overrun_q;

        Read_data = '0;
        if (sel_txd)      Read_data = {24'b0, tx_byte_q};
        else if (sel_rxd) Read_data = {24'b0, rx_data_q};
        else if (sel_con) Read_data = con_rd;
    end

    // Transmit serializer; uart_tx is registered so the line never glitches.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_byte_d  = tx_byte_q;
        uart_tx_d  = uart_tx_q;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                if (wr_txd) begin
                    tx_state_d = ST_START;
                    tx_byte_d  = Write_data[7:0];
                    tx_shift_d = Write_data[7:0];
                    uart_tx_d  = 1'b0;
                end
            end
            ST_START: if (tx_cnt_q == FULL) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = ST_DATA;
                uart_tx_d  = tx_shift_q[0];
            end
            ST_DATA: if (tx_cnt_q == FULL) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = ST_STOP;
                    uart_tx_d  = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    uart_tx_d  = tx_shift_q[1];
                end
            end
            ST_STOP: if (tx_cnt_q == FULL) begin
                tx_cnt_d   = '0;
                tx_state_d = ST_IDLE;
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Hardware sets are OR-ed in after W1C so a same-edge set wins.
    always_comb begin
        rx_int_en_d  = wr_con ? Write_data[CON_RX_INT_EN] : rx_int_en_q;
        tx_overrun_d = (tx_overrun_q & ~(wr_con & Write_data[CON_TX_OVR])) | (wr_txd & tx_busy);
        frame_err_d  = (frame_err_q & ~(wr_con & Write_data[CON_FRAME_ERR])) | rx_ferr;
        rx_overrun_d = (rx_overrun_q & ~(wr_con & Write_data[CON_RX_OVR]))
                     | (rx_done & rx_valid_q & ~rd_rxd);
        rx_valid_d   = rx_done | (rx_valid_q & ~rd_rxd);
        rx_data_d    = rx_done ? rx_byte : rx_data_q;
        irq_d        = rx_int_en_d & rx_valid_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_byte_q    <= '0;
            uart_tx_q    <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_int_en_q  <= 1'b0;
            tx_overrun_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_byte_q    <= tx_byte_d;
            uart_tx_q    <= uart_tx_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
            rx_int_en_q  <= rx_int_en_d;
            tx_overrun_q <= tx_overrun_d;
            irq_q        <= irq_d;
        end
    end

    assign uart_tx = uart_tx_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_mmio_uart.sv
// Self-checking bench for mmio_uart at DIV=16: decode table, directed frame sequences,
// and randomized TX/RX traffic checked against a frame-level reference model.
module tb_mmio_uart;

    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;
    localparam int          BITC = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] Read_data;
    logic        Hit;
    logic        uart_tx;
    logic        irq;

    mmio_uart #(.CLK_FREQ(1600), .BAUD(100), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .Hit        (Hit),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Receive-side reference model: register state implied by the frames driven so far.
    bit         m_valid, m_ovr, m_ferr, m_int_en;
    logic [7:0] m_data;

    // Frames seen on uart_tx ({stop, byte}) and frames expected there.
    logic [8:0] tx_q[$];
    logic [8:0] exp_tx[$];

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [31:0] rd;
    } dec_vec_t;
    dec_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic peek(input logic [31:0] addr, output logic [31:0] d);
        Address = addr;
        MemRead = 1'b0;
        #1;
        d = Read_data;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data);
        Address    = addr;
        Write_data = data;
        MemWrite   = 1'b1;
        @(negedge clk);
        MemWrite   = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        drive_write(addr, data);
    endtask

    task automatic rx_read(input string name);
        logic [31:0] d;
        @(negedge clk);
        Address = RXD;
        MemRead = 1'b1;
        #1;
        d = Read_data;
        @(negedge clk);
        MemRead = 1'b0;
        check(name, d, {24'b0, m_data});
        m_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        logic [9:0] fb;
        fb = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            uart_rx = fb[k];
            repeat (BITC - 1) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_rx(input string name);
        logic [31:0] d;
        peek(CON, d);
        check({name, "_con"}, {28'b0, d[4:1]}, {28'b0, m_int_en, m_ferr, m_ovr, m_valid});
        peek(RXD, d);
        check({name, "_rxd"}, d, {24'b0, m_data});
        check({name, "_irq"}, {31'b0, irq}, {31'b0, m_int_en & m_valid});
    endtask

    task automatic rx_frame(input string name, input logic [7:0] b, input bit good);
        send_frame(b, good);
        if (good) begin
            m_ovr   = m_ovr | m_valid;
            m_valid = 1'b1;
            m_data  = b;
        end else begin
            m_ferr = 1'b1;
        end
        check_rx(name);
    endtask

    task automatic model_reset();
        m_valid = 0; m_ovr = 0; m_ferr = 0; m_int_en = 0; m_data = '0;
    endtask

    // Independent serial decoder on uart_tx; frames interrupted by reset are dropped.
    logic [8:0] mon_sh;
    bit         mon_ok;
    always begin
        @(negedge uart_tx);
        mon_ok = rst_n;
        mon_sh = '0;
        for (int k = 0; k < 10; k++) begin
            repeat (k == 0 ? BITC / 2 : BITC) begin
                @(negedge clk);
                if (!rst_n) mon_ok = 0;
            end
            if (k == 0) begin
                if (uart_tx) mon_ok = 0;
            end else begin
                mon_sh = {uart_tx, mon_sh[8:1]};
            end
        end
        if (mon_ok) tx_q.push_back(mon_sh);
    end

    task automatic check_tx_queue(input string name);
        check({name, "_count"}, tx_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            check({name, "_frame"}, {23'b0, tx_q[i]}, {23'b0, exp_tx[i]});
        tx_q.delete();
        exp_tx.delete();
    endtask

    initial begin
        logic [31:0] d;
        logic [9:0]  fb;
        int          busy_cnt, tx_bad;
        logic [7:0]  b;
        bit          good, timed_out;

        vecs[0] = '{BASE,                  1'b1, 32'h0};
        vecs[1] = '{BASE + 32'd4,          1'b1, 32'h0};
        vecs[2] = '{BASE + 32'd8,          1'b1, 32'h0};
        vecs[3] = '{BASE + 32'd12,         1'b0, 32'h0};
        vecs[4] = '{BASE + 32'd1,          1'b1, 32'h0};
        vecs[5] = '{BASE + 32'd11,         1'b1, 32'h0};
        vecs[6] = '{BASE - 32'd4,          1'b0, 32'h0};
        vecs[7] = '{BASE ^ 32'h8000_0000,  1'b0, 32'h0};

        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            peek(vecs[i].addr, d);
            check("decode_hit", {31'b0, Hit}, {31'b0, vecs[i].hit});
            check("decode_rdata", d, vecs[i].rd);
        end

        // Single TX frame 0xA5, checked cycle by cycle.
        tx_q.delete();
        fb = {1'b1, 8'hA5, 1'b0};
        bus_write(TXD, 32'h0000_00A5);
        busy_cnt = 0;
        tx_bad   = 0;
        for (int i = 0; i < 10 * BITC + 15; i++) begin
            peek(CON, d);
            if (d[0]) busy_cnt++;
            if ((d[0] == 1'b1) != (i < 10 * BITC)) tx_bad++;
            if (uart_tx !== ((i < 10 * BITC) ? fb[i / BITC] : 1'b1)) tx_bad++;
            if (i % BITC == BITC / 2 && i < 10 * BITC)
                check("tx_a5_bit", {31'b0, uart_tx}, {31'b0, fb[i / BITC]});
            @(negedge clk);
        end
        check("tx_a5_busy_cycles", busy_cnt, 10 * BITC);
        check("tx_a5_bad_cycles", tx_bad, 0);
        peek(TXD, d);
        check("txd_readback", d, 32'hA5);
        tx_q.delete();

        // Write while busy is dropped and flagged; W1C of tx_overrun.
        bus_write(TXD, 32'h41);
        repeat (19) @(negedge clk);
        bus_write(TXD, 32'h42);
        peek(CON, d);
        check("tx_busy_con", d, 32'h21);
        peek(TXD, d);
        check("tx_busy_txd", d, 32'h41);
        bus_write(CON, 32'h20);
        peek(CON, d);
        check("tx_ovr_clear", d, 32'h01);
        repeat (200) @(negedge clk);
        exp_tx.push_back({1'b1, 8'h41});
        check_tx_queue("tx_busy");

        // RX with interrupt enabled, then read clears valid and irq.
        bus_write(CON, 32'h10);
        m_int_en = 1'b1;
        rx_frame("rx_3c", 8'h3C, 1'b1);
        rx_read("rx_3c_read");
        check_rx("rx_3c_after");

        // Overrun then frame error.
        rx_frame("rx_11", 8'h11, 1'b1);
        rx_frame("rx_22_ovr", 8'h22, 1'b1);
        rx_frame("rx_ferr", 8'h55, 1'b0);
        bus_write(CON, 32'h1C);
        m_ovr = 0; m_ferr = 0;
        check_rx("rx_w1c");
        rx_read("rx_22_read");

        // Short low glitch is rejected; receiver is still ready for a real frame.
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        check_rx("glitch");
        rx_frame("after_glitch", 8'hC3, 1'b1);
        rx_read("after_glitch_read");

        // Unmapped word with a load strobe.
        @(negedge clk);
        Address = BASE + 32'd12;
        MemRead = 1'b1;
        #1;
        check("unmapped_hit", {31'b0, Hit}, 32'h0);
        check("unmapped_rdata", Read_data, 32'h0);
        @(negedge clk);
        MemRead = 1'b0;

        // Randomized RX traffic against the model.
        m_int_en = 1'($urandom_range(0, 1));
        bus_write(CON, {27'b0, m_int_en, 4'b0});
        for (int i = 0; i < 6; i++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            rx_frame("rnd_rx", b, good);
            if ($urandom_range(0, 1) == 1) begin
                rx_read("rnd_rx_read");
                check_rx("rnd_rx_after_read");
            end
        end
        bus_write(CON, {27'b0, m_int_en, 4'b1100});
        m_ovr = 0; m_ferr = 0;
        check_rx("rnd_rx_clear");

        // Randomized back-to-back TX frames, each written in the first idle cycle.
        tx_q.delete();
        exp_tx.delete();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            timed_out = 1'b1;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                peek(CON, d);
                if (!d[0]) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            check("rnd_tx_poll_timeout", {31'b0, timed_out}, 32'h0);
            drive_write(TXD, {24'b0, b});
            exp_tx.push_back({1'b1, b});
        end
        repeat (200) @(negedge clk);
        check_tx_queue("rnd_tx");

        // Reset in the middle of a TX frame.
        bus_write(TXD, 32'h5A);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_uart_tx", {31'b0, uart_tx}, 32'h1);
        peek(CON, d);
        check("rst_mid_con", d, 32'h0);
        peek(TXD, d);
        check("rst_mid_txd", d, 32'h0);
        check("rst_mid_irq", {31'b0, irq}, 32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (170) @(negedge clk);
        check_rx("post_reset");
        tx_q.delete();
        exp_tx.delete();
        bus_write(TXD, 32'h96);
        exp_tx.push_back({1'b1, 8'h96});
        repeat (200) @(negedge clk);
        check_tx_queue("post_reset_tx");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped UART peripheral that responds to the CPU data-memory bus. It is the responder end of the load/store interface the pipeline drives with Address, Write_data, MemRead and MemWrite.
- It sits beside DataMEM. The top level selects Read_data from this block whenever Hit=1.
- It provides an 8N1 serial transmitter, an 8N1 receiver, a status/control register and a receive interrupt line.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- BASE_ADDR, 32'h40000018, byte address of TXD. RXD is at BASE+4 and CON is at BASE+8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  byte address from the CPU MEM stage.
- Write_data  in  32  store data.
- MemRead  in  1  load strobe.
- MemWrite  in  1  store strobe.
- Read_data  out  32  load data. Combinational. Zero when Hit=0.
- Hit  out  1  Address[31:2] equals one of the three register word addresses. Combinational.
- uart_rx  in  1  serial input. Asynchronous to clk.
- uart_tx  out  1  serial output. Registered. Idles high.
- irq  out  1  rx_int_en & rx_valid. Registered.

Behaviour:
- Reset is asynchronous and active-low; it is fully synchronous to clk after release.
- DIV = CLK_FREQ/BAUD, using integer division. An elaboration-time check requires DIV>=4.

Register map:
- TXD (BASE+0):
  - A write of [7:0] while the TX FSM is IDLE loads the byte and starts a frame.
  - A write while busy is ignored and sets tx_overrun.
  - A read returns {24'b0, last accepted TX byte}.
- RXD (BASE+4):
  - A read returns {24'b0, rx_data}.
  - A read with MemRead=1 clears rx_valid at the clock edge.
  - Writes are ignored.
- CON (BASE+8):
  - bit0 tx_busy (RO).
  - bit1 rx_valid (RO).
  - bit2 rx_overrun (W1C).
  - bit3 frame_err (W1C).
  - bit4 rx_int_en (RW).
  - bit5 tx_overrun (W1C).
  - All other bits read 0.

Bus rules:
- Register side effects happen only at posedge clk.
- With MemRead and MemWrite both high, the write takes effect and Read_data shows pre-edge state.
- Byte lanes are ignored; address bits [1:0] are ignored.

Reset values:
- uart_tx=1, irq=0, Read_data=0, all CON bits 0, rx_data=0, TX byte=0.
- Both FSMs are IDLE and all counters are 0.

TX FSM (IDLE, START, DATA, STOP):
- The TXD-write edge moves the FSM to START and drives uart_tx low; tx_busy=1 from that edge.
- START lasts DIV cycles.
- DATA sends 8 bits LSB-first, DIV cycles each.
- STOP holds uart_tx=1 for DIV cycles, then returns to IDLE.
- tx_busy is high for exactly 10*DIV cycles.
- A new write is accepted in the first IDLE cycle, which gives back-to-back frames with no gap.

RX path:
- Two-flop synchronizer on uart_rx, plus an FSM with states IDLE, START, DATA, STOP.
- IDLE to START on a synchronized low.
- After DIV/2 cycles the line is resampled:
  - high: return to IDLE (glitch rejected, no flags);
  - low: go to DATA.
- DATA samples 8 bits every DIV cycles, LSB-first, into a shift register.
- STOP samples after a further DIV cycles:
  - low: set frame_err, discard the byte, rx_valid unchanged;
  - high: rx_data <= byte and rx_valid <= 1. If rx_valid was already 1 and is not being cleared this edge, also set rx_overrun. The new byte overwrites.
- A byte completing on the same edge as an RXD read leaves rx_valid=1, latches the new byte and does not set rx_overrun.
- After STOP the FSM returns to IDLE at once, so it can detect a start bit in the next cycle.
- W1C on the same edge as a hardware set: the set wins.
- Reset mid-frame aborts both FSMs. uart_tx goes high asynchronously and the partial RX byte is lost.

Decomposition:
- Shared package uart_pkg holds:
  - register offsets TXD=0, RXD=4, CON=8;
  - CON bit indices;
  - the 2-bit FSM state encodings for IDLE, START, DATA, STOP.
- One sub-module, uart_rx_core, holds the synchronizer, RX FSM and bit counter. Its outputs are a byte, a done pulse and a frame_err pulse.
- The TX FSM and the register file stay in mmio_uart.

Test Plan:
All scenarios use CLK_FREQ=1600 and BAUD=100, giving DIV=16.
1. TX: write TXD=0x000000A5 -> uart_tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; CON bit0=1 for 160 cycles, then 0.
2. TX busy: write 0x41, then 0x42 twenty cycles later -> only 0x41 is serialized; CON=0x21 (tx_busy, tx_overrun); writing CON=0x20 clears tx_overrun.
3. RX: drive frame 0x3C, set CON bit4 -> irq=1 and CON bit1=1 within 2 cycles after the stop sample; RXD read returns 0x3C; the next cycle has rx_valid=0 and irq=0.
4. RX overrun and frame error:
   - two frames 0x11 then 0x22 without a read -> RXD=0x22, CON bit2=1;
   - a frame with a low stop bit -> CON bit3=1 and rx_data unchanged.
5. Glitch and decode: a 5-cycle low pulse on uart_rx -> no flags and the FSM returns to IDLE. A read at BASE+12 -> Hit=0, Read_data=0.
6. Reset mid-TX frame (reset low at cycle 50) -> uart_tx=1 immediately, CON=0; a TXD write after reset release transmits normally.
